// File: rtl/phy_tx_switch_n.sv
// GMII transmit switch: steers one MAC transmit stream to one of NPORTS PHY ports,
// changing ports only between frames and enforcing an inter-frame gap after each change.
module phy_tx_switch_n #(
  parameter int NPORTS  = 2,
  parameter int SEL_W   = 1,
  parameter int DW      = 8,
  parameter int IFG_MIN = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     select,
  input  logic [DW-1:0]        txdat,
  input  logic                 txen,
  input  logic                 txer,
  output logic [NPORTS*DW-1:0] port_txdat,
  output logic [NPORTS-1:0]    port_txen,
  output logic [NPORTS-1:0]    port_txer,
  output logic [SEL_W-1:0]     active_port,
  output logic                 active_valid,
  output logic                 switch_done,
  output logic [15:0]          drop_cnt
);

  localparam int CW = $clog2(IFG_MIN + 1);
  localparam logic [CW-1:0]    IFG_LOAD = CW'(IFG_MIN);
  localparam logic [SEL_W:0]   NPORTS_W = (SEL_W + 1)'(NPORTS);

  typedef enum logic [1:0] {ST_FWD, ST_GAP, ST_DROP} state_t;

  state_t                 state_reg;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       cur_sel;
  logic [CW-1:0]          gap_cnt_reg;
  logic                   fwd_en;
  logic                   selq_ok;
  logic [NPORTS*DW-1:0]   dat_next;
  logic [NPORTS-1:0]      en_next;
  logic [NPORTS-1:0]      er_next;

  assign active_port = cur_sel;
  assign selq_ok     = {1'b0, sel_q} < NPORTS_W;
  // Only the FWD state drives a port; a disabled selection leaves every port idle.
  assign fwd_en      = (state_reg == ST_FWD) && ({1'b0, cur_sel} < NPORTS_W);

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic hit;
      assign hit = fwd_en && (cur_sel == SEL_W'(gi));
      assign dat_next[gi*DW +: DW] = hit ? txdat : '0;
      assign en_next[gi]           = hit & txen;
      assign er_next[gi]           = hit & txer;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FWD;
      sel_q        <= '0;
      cur_sel      <= '0;
      active_valid <= 1'b1;
      switch_done  <= 1'b0;
      gap_cnt_reg  <= '0;
      drop_cnt     <= '0;
      port_txdat   <= '0;
      port_txen    <= '0;
      port_txer    <= '0;
    end else begin
      sel_q       <= select;
      switch_done <= 1'b0;
      port_txdat  <= dat_next;
      port_txen   <= en_next;
      port_txer   <= er_next;
      case (state_reg)
        ST_FWD: begin
          // A frame in progress always finishes on the old port.
          if ((sel_q != cur_sel) && !txen) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= IFG_LOAD;
          end
        end
        ST_GAP: begin
          if (txen) begin
            state_reg <= ST_DROP;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else if (gap_cnt_reg == CW'(1)) begin
            // Latest request wins; a reverted request still serves the gap, silently.
            cur_sel      <= sel_q;
            active_valid <= selq_ok;
            switch_done  <= (sel_q != cur_sel);
            state_reg    <= ST_FWD;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - CW'(1);
          end
        end
        ST_DROP: begin
          if (!txen) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= IFG_LOAD;
          end
        end
        default: state_reg <= ST_FWD;
      endcase
    end
  end

endmodule
